hyperbus_wb_bridge: RTL

//  Wishbone B4 classic slave feeding the hyperbus_fifo user port in the user clock domain.

---
 rtl/hyperbus_wb_bridge_pkg.sv | 23 ++
 rtl/hyperbus_wb_bridge_timeout.sv | 44 ++++
 rtl/hyperbus_wb_bridge.sv | 121 ++++++++++++
 3 files changed

// File: rtl/hyperbus_wb_bridge_pkg.sv
// rtl/hyperbus_wb_bridge_pkg.sv - shared FSM encoding and address helpers for the HyperBus user port
// Purpose: state encoding and byte-to-word address shift shared by the bridge and controller.
// Ports: none (package).
package hyperbus_wb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_WAIT = 3'd1,
    ST_WR_ACC  = 3'd2,
    ST_WR_DRN  = 3'd3,
    ST_ACK     = 3'd4,
    ST_ERR     = 3'd5
  } state_t;

  // HyperBus addresses 16-bit words, so byte addresses drop their LSB.
  localparam int HB_ADDR_SHIFT = 1;

  // States in which a downstream transaction is in flight and the watchdog runs.
  function automatic logic is_wait_state(input state_t s);
    return (s == ST_RD_WAIT) || (s == ST_WR_ACC) || (s == ST_WR_DRN);
  endfunction

endpackage

// File: rtl/hyperbus_wb_bridge_timeout.sv
// rtl/hyperbus_wb_bridge_timeout.sv - phase watchdog counter with clear, enable and expire
// Purpose: counts enabled cycles; flags expiry one cycle after the count reaches LIMIT-1.
// Ports:
//   i_clk     in  1  clock
//   i_rst_n   in  1  synchronous active-low reset
//   i_clr     in  1  restart the count (wins over i_en)
//   i_en      in  1  count this cycle
//   o_expire  out 1  registered expiry flag
module hyperbus_wb_bridge_timeout #(
  parameter int LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam int CW = (LIMIT > 2) ? $clog2(LIMIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

  logic [CW-1:0] r_cnt;
  logic          r_expire;

  // Expiry is registered, so the consumer reacts one cycle after LAST is seen;
  // a phase therefore lasts LIMIT+1 cycles counting its first cycle.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else if (i_clr) begin
      r_cnt    <= '0;
      r_expire <= 1'b0;
    end else if (i_en) begin
      r_cnt    <= r_cnt + 1'b1;
      r_expire <= (r_cnt == LAST);
    end else begin
      r_expire <= 1'b0;
    end
  end

  assign o_expire = r_expire;

endmodule

// File: rtl/hyperbus_wb_bridge.sv
// rtl/hyperbus_wb_bridge.sv - Wishbone B4 classic slave driving the hyperbus_fifo user port
// Purpose: one WB cycle -> one rrq/wrq pulse; waits for rx_valid (read) or TX drain (write),
//          then acks; a per-phase watchdog converts lost transactions into wb_err_o.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   wb_adr_i/dat_i/sel_i/we_i       WB request (byte address, data, selects, direction)
//   wb_cyc_i, wb_stb_i              WB cycle and strobe
//   wb_dat_o, wb_ack_o, wb_err_o    WB read data, one-cycle ack, one-cycle error
//   rrq, wrq                        one-cycle read/write request to hyperbus_fifo
//   adr_o, tx_dat_o                 word address and write data, held until completion
//   tx_ready                        TX FIFO empty
//   rx_dat_i, rx_valid              RX data and its one-cycle valid pulse
module hyperbus_wb_bridge
  import hyperbus_wb_bridge_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   wb_adr_i,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic [DATA_WIDTH/8-1:0] wb_sel_i,
  input  logic                    wb_we_i,
  input  logic                    wb_cyc_i,
  input  logic                    wb_stb_i,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic                    wb_ack_o,
  output logic                    wb_err_o,
  output logic                    rrq,
  output logic                    wrq,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  output logic [DATA_WIDTH-1:0]   tx_dat_o,
  input  logic                    tx_ready,
  input  logic [DATA_WIDTH-1:0]   rx_dat_i,
  input  logic                    rx_valid
);

  localparam logic [DATA_WIDTH/8-1:0] SEL_ALL = '1;

  state_t                  r_state, w_next;
  logic                    w_req, w_start_rd, w_start_wr, w_clr, w_busy, w_expire;
  logic                    r_rrq, r_wrq, r_abort;
  logic [ADDR_WIDTH-1:0]   r_adr;
  logic [DATA_WIDTH-1:0]   r_tx_dat, r_rx_dat;

  assign w_req  = wb_cyc_i & wb_stb_i;
  assign w_busy = is_wait_state(r_state);
  // Any state change restarts the watchdog so each phase gets its own budget.
  assign w_clr  = (w_next != r_state);

  hyperbus_wb_bridge_timeout #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_clr    (w_clr),
    .i_en     (w_busy),
    .o_expire (w_expire)
  );

  always_comb begin
    w_next     = r_state;
    w_start_rd = 1'b0;
    w_start_wr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (!wb_we_i) begin
            w_next     = ST_RD_WAIT;
            w_start_rd = 1'b1;
          end else if (wb_sel_i != SEL_ALL) begin
            w_next = ST_ERR;
          end else if (tx_ready) begin
            w_next     = ST_WR_ACC;
            w_start_wr = 1'b1;
          end
        end
      end
      // Completion events take priority over a watchdog expiry in the same cycle.
      ST_WR_ACC:  if (!tx_ready) w_next = ST_WR_DRN; else if (w_expire) w_next = ST_ERR;
      ST_WR_DRN:  if (tx_ready)  w_next = ST_ACK;    else if (w_expire) w_next = ST_ERR;
      ST_RD_WAIT: if (rx_valid)  w_next = ST_ACK;    else if (w_expire) w_next = ST_ERR;
      ST_ACK:     w_next = ST_IDLE;
      ST_ERR:     w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_rrq    <= 1'b0;
      r_wrq    <= 1'b0;
      r_abort  <= 1'b0;
      r_adr    <= '0;
      r_tx_dat <= '0;
      r_rx_dat <= '0;
    end else begin
      r_state <= w_next;
      r_rrq   <= w_start_rd;
      r_wrq   <= w_start_wr;
      if (w_start_rd || w_start_wr) r_adr <= wb_adr_i >> HB_ADDR_SHIFT;
      if (w_start_wr) r_tx_dat <= wb_dat_i;
      if ((r_state == ST_RD_WAIT) && rx_valid) r_rx_dat <= rx_dat_i;
      // Sticky until IDLE: a master that restarts early must not see the old ack.
      if (r_state == ST_IDLE) r_abort <= 1'b0;
      else if (!wb_cyc_i)     r_abort <= 1'b1;
    end
  end

  assign wb_ack_o = (r_state == ST_ACK) && !r_abort && wb_cyc_i;
  assign wb_err_o = (r_state == ST_ERR) && !r_abort && wb_cyc_i;
  assign wb_dat_o = r_rx_dat;
  assign rrq      = r_rrq;
  assign wrq      = r_wrq;
  assign adr_o    = r_adr;
  assign tx_dat_o = r_tx_dat;

endmodule
